async_fifo: RTL and testbench



---
 rtl/async_fifo.sv | 100 ++++++++++
 tb/tb_async_fifo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// rtl/async_fifo.sv - single-clock FIFO with overflow/underflow error reporting
//
// Purpose:
//   Buffers WIDTH-bit words between a producer and a consumer sharing clk_i.
//   Rejected writes (full) and reads (empty) leave contents and pointers intact
//   and raise a registered error flag.
//
// Ports:
//   clk_i       in   1      clock, all logic on posedge
//   rst_n_i     in   1      synchronous active-low reset
//   wr_en_i     in   1      write request
//   wdata_i     in   WIDTH  write data, sampled with wr_en_i
//   full_o      out  1      FIFO holds DEPTH entries
//   wr_error_o  out  1      write attempted while full
//   rd_en_i     in   1      read request
//   rdata_o     out  WIDTH  read data, valid the cycle after an accepted read
//   empty_o     out  1      FIFO holds 0 entries
//   rd_error_o  out  1      read attempted while empty
//
// Configuration:
//   ASYNC_FIFO_STICKY_ERR_EN - when defined, error outputs latch high until
//   reset; otherwise they are single-cycle pulses.

module async_fifo #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int PTR_WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    output logic             wr_error_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             rd_error_o
);

    localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the address bits coincide.
    logic [PTR_WIDTH:0]   wr_ptr;
    logic [PTR_WIDTH:0]   rd_ptr;
    logic [WIDTH-1:0]     mem [DEPTH];

    logic                 wr_accept;
    logic                 rd_accept;
    logic                 wr_reject;
    logic                 rd_reject;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                     (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);

    // Decisions use the flags as they stand before the edge: a read on a full
    // FIFO is taken while the concurrent write is refused, and a write on an
    // empty FIFO is taken while the concurrent read is refused (no fall-through).
    assign wr_accept = wr_en_i & ~full_o;
    assign rd_accept = rd_en_i & ~empty_o;
    assign wr_reject = wr_en_i & full_o;
    assign rd_reject = rd_en_i & empty_o;

    // Storage is never cleared; stale words are unreachable once the pointers
    // are reset.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && wr_accept) begin
            mem[wr_ptr[PTR_WIDTH-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rdata_o    <= '0;
            wr_error_o <= 1'b0;
            rd_error_o <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            // rdata_o holds its previous value on cycles without an accepted read.
            if (rd_accept) begin
                rdata_o <= mem[rd_ptr[PTR_WIDTH-1:0]];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
`ifdef ASYNC_FIFO_STICKY_ERR_EN
            wr_error_o <= wr_error_o | wr_reject;
            rd_error_o <= rd_error_o | rd_reject;
`else
            wr_error_o <= wr_reject;
            rd_error_o <= rd_reject;
`endif
        end
    end

endmodule

// File: tb/tb_async_fifo.sv
// tb/tb_async_fifo.sv - scoreboard testbench for async_fifo

module tb_async_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk_i = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             wr_en_i = 1'b0;
    logic [WIDTH-1:0] wdata_i = '0;
    logic             full_o;
    logic             wr_error_o;
    logic             rd_en_i = 1'b0;
    logic [WIDTH-1:0] rdata_o;
    logic             empty_o;
    logic             rd_error_o;

    async_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_WIDTH(4)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .wr_en_i    (wr_en_i),
        .wdata_i    (wdata_i),
        .full_o     (full_o),
        .wr_error_o (wr_error_o),
        .rd_en_i    (rd_en_i),
        .rdata_o    (rdata_o),
        .empty_o    (empty_o),
        .rd_error_o (rd_error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             werr;
        logic             rerr;
        logic             full;
        logic             empty;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] last_rd = '0;
    logic             werr_s = 1'b0;
    logic             rerr_s = 1'b0;
    int               n_checks = 0;
    int               n_pass = 0;
    bit               stim_done = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Drive one cycle of stimulus and push the outcome the model predicts for
    // the edge that follows.
    task automatic cyc(input logic rst_n, input logic we, input logic [WIDTH-1:0] wd,
                       input logic re);
        exp_t e;
        bit   was_full;
        bit   was_empty;
        bit   werr;
        bit   rerr;
        @(negedge clk_i);
        rst_n_i = rst_n;
        wr_en_i = we;
        wdata_i = wd;
        rd_en_i = re;
        if (!rst_n) begin
            model_q.delete();
            last_rd = '0;
            werr_s  = 1'b0;
            rerr_s  = 1'b0;
            werr    = 1'b0;
            rerr    = 1'b0;
        end else begin
            was_full  = (model_q.size() == DEPTH);
            was_empty = (model_q.size() == 0);
            werr = we && was_full;
            rerr = re && was_empty;
            if (re && !was_empty) last_rd = model_q.pop_front();
            if (we && !was_full) model_q.push_back(wd);
`ifdef ASYNC_FIFO_STICKY_ERR_EN
            werr_s = werr_s | werr;
            rerr_s = rerr_s | rerr;
            werr   = werr_s;
            rerr   = rerr_s;
`endif
        end
        e.d     = last_rd;
        e.werr  = werr;
        e.rerr  = rerr;
        e.full  = (model_q.size() == DEPTH);
        e.empty = (model_q.size() == 0);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, 1'b0);
    endtask

    // Monitor: one expected record per edge, compared just after that edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rdata",    int'(rdata_o),    int'(e.d));
                chk("wr_error", int'(wr_error_o), int'(e.werr));
                chk("rd_error", int'(rd_error_o), int'(e.rerr));
                chk("full",     int'(full_o),     int'(e.full));
                chk("empty",    int'(empty_o),    int'(e.empty));
            end
        end
    end

    initial begin : stimulus
        // reset
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        // 1/2: fill with 0x01..0x10, then drain in order
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0);
        idle(1);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, '0, 1'b1);
        idle(2);
        // 3: overflow with 0xAA, which must never come out
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b1, 8'(8'h20 + i), 1'b0);
        cyc(1'b1, 1'b1, 8'hAA, 1'b0);
        idle(2);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, '0, 1'b1);
        idle(2);
        // 4: underflow after draining; rdata holds the 16th word
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b1, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, '0, 1'b1);
        idle(2);
        // full + simultaneous read/write: read taken, write refused
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0);
        cyc(1'b1, 1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, '0, 1'b1);
        idle(2);
        // 5: concurrent 32 writes / 33 reads across pointer wrap
        for (int i = 0; i < 33; i++) cyc(1'b1, (i < 32), 8'(8'h40 + i), 1'b1);
        idle(2);
        // 6: reset mid-operation
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b1, 8'(8'hE0 + i), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b1);
        idle(3);
        stim_done = 1'b1;
    end

    initial begin : finisher
        int budget;
        budget = 0;
        while (!(stim_done && exp_q.size() == 0) && budget < 5000) begin
            @(negedge clk_i);
            budget++;
        end
        n_checks++;
        if (stim_done && exp_q.size() == 0) n_pass++;
        else $display("FAIL timeout: pending=%0d, expected 0 within 5000 cycles", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
